// File: rtl/mult_cdb_writer.sv
// Multiplier functional unit: takes one op from a reservation station,
// multiplies over a fixed latency and broadcasts {tag, result} on the CDB.
module mult_cdb_writer #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3,
    parameter int LAT    = 3
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Flush,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [TAG_W-1:0]  iss_tag,
    input  logic [DATA_W-1:0] iss_vj,
    input  logic [DATA_W-1:0] iss_vk,
    input  logic              iss_op,
    output logic              busy,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT,
        BCAST
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [TAG_W-1:0]    tag_q;
    logic [DATA_W-1:0]   vj_q;
    logic [DATA_W-1:0]   vk_q;
    logic                op_q;
    logic [DATA_W-1:0]   res_q;
    logic [TAG_W-1:0]    cdb_tag_q;
    logic [DATA_W-1:0]   cdb_data_q;

    logic                accept;
    logic                exec_done;
    logic                grant_ok;
    logic [2*DATA_W-1:0] prod;

    // Flush vetoes any accept, including the back-to-back one from BCAST.
    assign iss_ready = (state_q == IDLE) || (state_q == BCAST);
    assign accept    = iss_valid & iss_ready & ~Flush;
    assign exec_done = (state_q == EXEC) && (cnt_q == 4'd0) && !Flush;
    assign grant_ok  = (state_q == WAIT) && cdb_grant && !Flush;

    assign prod = (2*DATA_W)'(vj_q) * (2*DATA_W)'(vk_q);

    assign busy      = (state_q != IDLE);
    assign cdb_req   = (state_q == WAIT);
    assign cdb_valid = (state_q == BCAST);
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                    cnt_d   = CNT_INIT;
                end
            end
            EXEC: begin
                if (Flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WAIT: begin
                if (Flush) begin
                    state_d = IDLE;
                end else if (cdb_grant) begin
                    state_d = BCAST;
                end
            end
            BCAST: begin
                if (accept) begin
                    state_d = EXEC;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output tag/data only move on the grant edge so they hold between broadcasts.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            tag_q      <= '0;
            vj_q       <= '0;
            vk_q       <= '0;
            op_q       <= 1'b0;
            res_q      <= '0;
            cdb_tag_q  <= '0;
            cdb_data_q <= '0;
        end else begin
            if (accept) begin
                tag_q <= iss_tag;
                vj_q  <= iss_vj;
                vk_q  <= iss_vk;
                op_q  <= iss_op;
            end
            if (exec_done) begin
                res_q <= op_q ? prod[2*DATA_W-1:DATA_W] : prod[DATA_W-1:0];
            end
            if (grant_ok) begin
                cdb_tag_q  <= tag_q;
                cdb_data_q <= res_q;
            end
        end
    end

endmodule

// File: tb/tb_mult_cdb_writer.sv
// Bench for mult_cdb_writer: per-cycle compare against an op-age model
// plus directed scenarios with hand-computed results and latencies.
module tb_mult_cdb_writer;

    localparam int DW  = 16;
    localparam int TW  = 3;
    localparam int LAT = 3;

    logic          Clock;
    logic          Resetn;
    logic          Flush;
    logic          iss_valid;
    logic          iss_ready;
    logic [TW-1:0] iss_tag;
    logic [DW-1:0] iss_vj;
    logic [DW-1:0] iss_vk;
    logic          iss_op;
    logic          busy;
    logic          cdb_req;
    logic          cdb_grant;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;

    int n_cmp = 0;
    int n_bad = 0;

    mult_cdb_writer #(.DATA_W(DW), .TAG_W(TW), .LAT(LAT)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .Flush     (Flush),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_tag   (iss_tag),
        .iss_vj    (iss_vj),
        .iss_vk    (iss_vk),
        .iss_op    (iss_op),
        .busy      (busy),
        .cdb_req   (cdb_req),
        .cdb_grant (cdb_grant),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: an op in flight has an age in cycles since acceptance;
    // it requests the bus once age reaches LAT, broadcasts after a grant.
    bit            m_op;
    int            m_age;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_res;
    bit            m_bcast;
    logic [TW-1:0] m_btag;
    logic [DW-1:0] m_bdata;
    bit            m_acc;
    bit            m_nb;
    logic [31:0]   m_prod;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m_op    = 0;
            m_age   = 0;
            m_bcast = 0;
            m_btag  = '0;
            m_bdata = '0;
        end else begin
            m_acc = iss_valid && !m_op && !Flush;
            m_nb  = 0;
            if (m_op) begin
                if (Flush) begin
                    m_op = 0;
                end else if (m_age >= LAT && cdb_grant) begin
                    m_nb    = 1;
                    m_btag  = m_tag;
                    m_bdata = m_res;
                    m_op    = 0;
                end else begin
                    m_age++;
                end
            end
            if (m_acc) begin
                m_op   = 1;
                m_age  = 0;
                m_tag  = iss_tag;
                m_prod = {16'd0, iss_vj} * {16'd0, iss_vk};
                m_res  = iss_op ? m_prod[31:16] : m_prod[15:0];
            end
            m_bcast = m_nb;
        end
    end

    always @(negedge Clock) begin
        if (Resetn) begin
            chk("m_ready", 32'(iss_ready), 32'(!m_op));
            chk("m_busy", 32'(busy), 32'(m_op || m_bcast));
            chk("m_req", 32'(cdb_req), 32'(m_op && m_age >= LAT));
            chk("m_valid", 32'(cdb_valid), 32'(m_bcast));
            chk("m_tag", 32'(cdb_tag), 32'(m_btag));
            chk("m_data", 32'(cdb_data), 32'(m_bdata));
        end
    end

    task automatic drive_issue(input logic [TW-1:0] t, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic op);
        iss_valid = 1'b1;
        iss_tag   = t;
        iss_vj    = a;
        iss_vk    = b;
        iss_op    = op;
    endtask

    // Steps negedges until a broadcast; grant withheld for gd request cycles.
    task automatic wait_bcast(input int gd, output int lat, output int reqc,
                              output logic [TW-1:0] otag,
                              output logic [DW-1:0] odata);
        int w;
        w     = 0;
        lat   = -1;
        reqc  = 0;
        otag  = '0;
        odata = '0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge Clock);
            if (k == 1) begin
                iss_valid = 1'b0;
                iss_vj    = DW'($urandom);
                iss_vk    = DW'($urandom);
                iss_tag   = TW'($urandom);
                iss_op    = 1'($urandom);
            end
            if (cdb_req) begin
                reqc++;
                w++;
                cdb_grant = (w > gd);
            end
            if (cdb_valid) begin
                lat   = k - 1;
                otag  = cdb_tag;
                odata = cdb_data;
                cdb_grant = 1'b0;
                break;
            end
        end
        cdb_grant = 1'b0;
    endtask

    int            lat;
    int            rc;
    int            nv;
    logic [TW-1:0] t;
    logic [DW-1:0] d;

    initial begin
        Resetn    = 1'b0;
        Flush     = 1'b0;
        iss_valid = 1'b0;
        iss_tag   = '0;
        iss_vj    = '0;
        iss_vk    = '0;
        iss_op    = 1'b0;
        cdb_grant = 1'b0;
        #3;
        chk("rst_ready", 32'(iss_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(cdb_req), 32'd0);
        chk("rst_valid", 32'(cdb_valid), 32'd0);
        chk("rst_tag", 32'(cdb_tag), 32'd0);
        chk("rst_data", 32'(cdb_data), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;

        @(negedge Clock);
        drive_issue(3'd5, 16'd7, 16'd6, 1'b0);
        wait_bcast(0, lat, rc, t, d);
        chk("t2_lat", 32'(lat), 32'd4);
        chk("t2_reqc", 32'(rc), 32'd1);
        chk("t2_tag", 32'(t), 32'd5);
        chk("t2_data", 32'(d), 32'h002A);
        @(negedge Clock);
        chk("t2_hold", 32'(cdb_data), 32'h002A);

        @(negedge Clock);
        drive_issue(3'd1, 16'hFFFF, 16'hFFFF, 1'b1);
        wait_bcast(0, lat, rc, t, d);
        chk("t3_hi", 32'(d), 32'hFFFE);
        @(negedge Clock);
        drive_issue(3'd1, 16'hFFFF, 16'hFFFF, 1'b0);
        wait_bcast(0, lat, rc, t, d);
        chk("t3_lo", 32'(d), 32'h0001);

        @(negedge Clock);
        drive_issue(3'd3, 16'h1234, 16'h0010, 1'b0);
        wait_bcast(5, lat, rc, t, d);
        chk("t4_lat", 32'(lat), 32'd9);
        chk("t4_reqc", 32'(rc), 32'd6);
        chk("t4_data", 32'(d), 32'h2340);

        @(negedge Clock);
        drive_issue(3'd1, 16'h0100, 16'h0300, 1'b1);
        wait_bcast(0, lat, rc, t, d);
        chk("t5a_data", 32'(d), 32'h0003);
        drive_issue(3'd2, 16'd3, 16'd4, 1'b0);
        wait_bcast(0, lat, rc, t, d);
        chk("t5b_lat", 32'(lat), 32'd4);
        chk("t5b_tag", 32'(t), 32'd2);
        chk("t5b_data", 32'(d), 32'd12);

        @(negedge Clock);
        drive_issue(3'd4, 16'd9, 16'd9, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clock);
            if (k == 1) iss_valid = 1'b0;
            if (cdb_req) break;
        end
        Flush     = 1'b1;
        cdb_grant = 1'b1;
        @(negedge Clock);
        Flush     = 1'b0;
        cdb_grant = 1'b0;
        chk("t6a_req", 32'(cdb_req), 32'd0);
        chk("t6a_busy", 32'(busy), 32'd0);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            nv += int'(cdb_valid);
        end
        chk("t6a_nobcast", 32'(nv), 32'd0);

        @(negedge Clock);
        drive_issue(3'd6, 16'd5, 16'd5, 1'b0);
        wait_bcast(0, lat, rc, t, d);
        chk("t6b_lat", 32'(lat), 32'd4);
        chk("t6b_data", 32'(d), 32'h0019);
        Flush = 1'b1;
        drive_issue(3'd7, 16'd2, 16'd2, 1'b0);
        @(negedge Clock);
        Flush     = 1'b0;
        iss_valid = 1'b0;
        chk("t6b_busy", 32'(busy), 32'd0);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            nv += int'(cdb_valid);
        end
        chk("t6b_nobcast", 32'(nv), 32'd0);

        @(negedge Clock);
        Flush = 1'b1;
        drive_issue(3'd7, 16'd2, 16'd2, 1'b0);
        @(negedge Clock);
        Flush     = 1'b0;
        iss_valid = 1'b0;
        chk("t6c_busy", 32'(busy), 32'd0);

        @(negedge Clock);
        drive_issue(3'd5, 16'd2, 16'd3, 1'b0);
        @(negedge Clock);
        iss_valid = 1'b0;
        chk("t1_exec_busy", 32'(busy), 32'd1);
        #2;
        Resetn = 1'b0;
        #1;
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_ready", 32'(iss_ready), 32'd1);
        chk("t1_req", 32'(cdb_req), 32'd0);
        chk("t1_tag", 32'(cdb_tag), 32'd0);
        chk("t1_data", 32'(cdb_data), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            nv += int'(cdb_valid);
        end
        chk("t1_nobcast", 32'(nv), 32'd0);

        @(negedge Clock);
        drive_issue(3'd1, 16'd10, 16'd10, 1'b0);
        wait_bcast(0, lat, rc, t, d);
        chk("post_lat", 32'(lat), 32'd4);
        chk("post_data", 32'(d), 32'h0064);

        @(negedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
